fight_referee: RTL and testbench

// Tracks player and enemy health during a bout and decides its outcome.

---
 rtl/game_pkg.sv | 11 +
 rtl/hit_tracker.sv | 45 ++++
 rtl/fight_referee.sv | 93 +++++++++
 tb/tb_fight_referee.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants: referee states and the screen codes exchanged with screen control.
package game_pkg;

  typedef enum logic [1:0] {IDLE, FIGHT, WIN, LOSE} referee_state_t;

  localparam logic [7:0] SCR_TITLE   = 8'h00;
  localparam logic [7:0] SCR_GAME    = 8'h01;
  localparam logic [7:0] SCR_VICTORY = 8'h02;
  localparam logic [7:0] SCR_DEFEAT  = 8'h03;

endpackage

// File: rtl/hit_tracker.sv
// One fighter's health and post-hit cooldown counters.
// Hits are sampled only when tick_en is high, and are ignored while the cooldown runs.
module hit_tracker #(
  parameter int MAX_HEALTH   = 8,
  parameter int HIT_COOLDOWN = 16,
  localparam int HW = $clog2(MAX_HEALTH + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          load,
  input  logic          tick_en,
  input  logic          hit,
  output logic [HW-1:0] health,
  output logic          lethal
);

  localparam int CW = (HIT_COOLDOWN > 0) ? $clog2(HIT_COOLDOWN + 1) : 1;
  localparam logic [HW-1:0] HEALTH_MAX = HW'(MAX_HEALTH);
  localparam logic [CW-1:0] COOL_MAX   = CW'(HIT_COOLDOWN);

  logic [CW-1:0] cool;
  logic          land;

  assign land   = tick_en && hit && (cool == '0) && (health != '0);
  // Lets the referee give a bout-ending hit priority over an abort in the same cycle.
  assign lethal = land && (health == HW'(1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      health <= HEALTH_MAX;
      cool   <= '0;
    end else if (load) begin
      health <= HEALTH_MAX;
      cool   <= '0;
    end else if (tick_en) begin
      if (land) begin
        health <= health - HW'(1);
        cool   <= COOL_MAX;
      end else if (cool != '0) begin
        cool   <= cool - CW'(1);
      end
    end
  end

endmodule

// File: rtl/fight_referee.sv
// Bout referee: tracks both fighters' health and drives the victory/defeat levels
// into screen control. Outputs decode registered state only.
module fight_referee
  import game_pkg::*;
#(
  parameter int MAX_HEALTH   = 8,
  parameter int HIT_COOLDOWN = 16,
  localparam int HW = $clog2(MAX_HEALTH + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          frame_tick,
  input  logic [7:0]    screen_code,
  input  logic          player_hit,
  input  logic          enemy_hit,
  output logic          VICTORY_sig,
  output logic          DEFEAT_sig,
  output logic [HW-1:0] player_health,
  output logic [HW-1:0] enemy_health
);

  referee_state_t state_q, state_d;
  logic           load;
  logic           tick_en;
  logic           player_lethal;
  logic           enemy_lethal;

  assign tick_en = (state_q == FIGHT) && frame_tick;

  hit_tracker #(
    .MAX_HEALTH   (MAX_HEALTH),
    .HIT_COOLDOWN (HIT_COOLDOWN)
  ) u_player (
    .Clk     (Clk),
    .Reset   (Reset),
    .load    (load),
    .tick_en (tick_en),
    .hit     (player_hit),
    .health  (player_health),
    .lethal  (player_lethal)
  );

  hit_tracker #(
    .MAX_HEALTH   (MAX_HEALTH),
    .HIT_COOLDOWN (HIT_COOLDOWN)
  ) u_enemy (
    .Clk     (Clk),
    .Reset   (Reset),
    .load    (load),
    .tick_en (tick_en),
    .hit     (enemy_hit),
    .health  (enemy_health),
    .lethal  (enemy_lethal)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        // Healths are held at full while idle, so a bout always starts fresh.
        load = 1'b1;
        if (screen_code == SCR_GAME) state_d = FIGHT;
      end
      FIGHT: begin
        if (player_health == '0) begin
          state_d = LOSE;
        end else if (enemy_health == '0) begin
          state_d = WIN;
        end else if ((screen_code == SCR_TITLE) && !(player_lethal || enemy_lethal)) begin
          state_d = IDLE;
          load    = 1'b1;
        end
      end
      WIN, LOSE: begin
        if (screen_code == SCR_TITLE) begin
          state_d = IDLE;
          load    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign VICTORY_sig = (state_q == WIN);
  assign DEFEAT_sig  = (state_q == LOSE);

endmodule

// File: tb/tb_fight_referee.sv
// Directed bench for fight_referee with MAX_HEALTH=3, HIT_COOLDOWN=2.
module tb_fight_referee;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_tick;
  logic [7:0] screen_code;
  logic       player_hit;
  logic       enemy_hit;
  logic       VICTORY_sig;
  logic       DEFEAT_sig;
  logic [1:0] player_health;
  logic [1:0] enemy_health;

  int checks = 0;
  int errors = 0;

  fight_referee #(
    .MAX_HEALTH   (3),
    .HIT_COOLDOWN (2)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_tick    (frame_tick),
    .screen_code   (screen_code),
    .player_hit    (player_hit),
    .enemy_hit     (enemy_hit),
    .VICTORY_sig   (VICTORY_sig),
    .DEFEAT_sig    (DEFEAT_sig),
    .player_health (player_health),
    .enemy_health  (enemy_health)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) clk1();
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    clk1();
    frame_tick = 1'b0;
  endtask

  // Expected health after each of ticks 1..7 with the hit held (cooldown 2).
  int exp_after_tick [7] = '{2, 2, 2, 1, 1, 1, 0};

  initial begin
    Reset       = 1'b1;
    frame_tick  = 1'b0;
    screen_code = 8'h00;
    player_hit  = 1'b0;
    enemy_hit   = 1'b0;
    #12;
    chk("reset_victory", VICTORY_sig, 0);
    chk("reset_defeat", DEFEAT_sig, 0);
    chk("reset_player_health", player_health, 3);
    chk("reset_enemy_health", enemy_health, 3);
    clk1();
    Reset = 1'b0;
    idle(2);

    // 1: enemy worn down to zero -> victory
    screen_code = 8'h01;
    clk1();
    enemy_hit = 1'b1;
    for (int k = 0; k < 7; k++) begin
      do_tick();
      chk($sformatf("t1_enemy_tick%0d", k + 1), enemy_health, exp_after_tick[k]);
      chk($sformatf("t1_player_tick%0d", k + 1), player_health, 3);
      if (k < 6) idle(3);
    end
    chk("t1_victory_at_E", VICTORY_sig, 0);
    enemy_hit = 1'b0;
    clk1();
    chk("t1_victory_at_E1", VICTORY_sig, 1);
    chk("t1_defeat_at_E1", DEFEAT_sig, 0);

    // 4: other screen codes hold the outcome, TITLE re-arms
    screen_code = 8'h02;
    for (int i = 0; i < 50; i++) begin
      clk1();
      chk("t4_victory_hold", VICTORY_sig, 1);
    end
    screen_code = 8'h00;
    clk1();
    chk("t4_victory_clear", VICTORY_sig, 0);
    chk("t4_enemy_reload", enemy_health, 3);
    chk("t4_player_reload", player_health, 3);

    // 2: simultaneous knockout -> defeat wins
    screen_code = 8'h01;
    clk1();
    player_hit = 1'b1;
    enemy_hit  = 1'b1;
    for (int k = 0; k < 7; k++) begin
      do_tick();
      if (k < 6) idle(3);
    end
    chk("t2_player_zero", player_health, 0);
    chk("t2_enemy_zero", enemy_health, 0);
    player_hit = 1'b0;
    enemy_hit  = 1'b0;
    clk1();
    chk("t2_defeat", DEFEAT_sig, 1);
    chk("t2_no_victory", VICTORY_sig, 0);
    idle(3);
    chk("t2_no_victory_later", VICTORY_sig, 0);
    screen_code = 8'h00;
    clk1();
    chk("t2_defeat_clear", DEFEAT_sig, 0);

    // 3: hits without frame_tick do nothing
    screen_code = 8'h01;
    clk1();
    enemy_hit = 1'b1;
    idle(20);
    chk("t3_enemy_unchanged", enemy_health, 3);
    chk("t3_player_unchanged", player_health, 3);
    chk("t3_no_victory", VICTORY_sig, 0);
    do_tick();
    chk("t3_still_fighting", enemy_health, 2);
    enemy_hit = 1'b0;

    // 5: abort mid-bout reloads; new bout starts with cooldown clear
    clk1();
    screen_code = 8'h00;
    clk1();
    chk("t5_abort_enemy_reload", enemy_health, 3);
    chk("t5_abort_no_flags", VICTORY_sig | DEFEAT_sig, 0);
    screen_code = 8'h01;
    clk1();
    enemy_hit = 1'b1;
    do_tick();
    chk("t5_fresh_first_hit", enemy_health, 2);

    // Final hit in the same cycle as TITLE: outcome beats abort
    do_tick();
    do_tick();
    do_tick();
    chk("pri_enemy_one", enemy_health, 1);
    do_tick();
    do_tick();
    screen_code = 8'h00;
    do_tick();
    chk("pri_enemy_zero", enemy_health, 0);
    enemy_hit = 1'b0;
    clk1();
    chk("pri_victory", VICTORY_sig, 1);
    clk1();
    chk("pri_rearm", VICTORY_sig, 0);
    chk("pri_rearm_health", enemy_health, 3);

    // 6: asynchronous reset between edges mid-bout
    screen_code = 8'h01;
    clk1();
    enemy_hit = 1'b1;
    do_tick();
    chk("t6_pre_reset", enemy_health, 2);
    #2;
    Reset      = 1'b1;
    frame_tick = 1'b1;
    #1;
    chk("t6_async_health", enemy_health, 3);
    chk("t6_async_flags", VICTORY_sig | DEFEAT_sig, 0);
    clk1();
    chk("t6_no_tick_in_reset", enemy_health, 3);
    Reset      = 1'b0;
    frame_tick = 1'b0;
    clk1();
    chk("t6_restart_health", enemy_health, 3);
    do_tick();
    chk("t6_restart_hit", enemy_health, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
